// File: rtl/qracc_pkg.sv
// Shared types and defaults for the QR accelerator output path.
// Vector type, bus/FIFO defaults and serializer state encoding.
package qracc_pkg;

  localparam int QRACC_OUT_ELEMS  = 32;
  localparam int QRACC_OUT_BITS   = 4;
  localparam int QRACC_OUT_BUS_W  = 32;
  localparam int QRACC_OUT_FIFO_D = 2;

  typedef logic [QRACC_OUT_ELEMS-1:0][QRACC_OUT_BITS-1:0]
    qracc_outvec_t;

  typedef enum logic {
    S_IDLE,
    S_SEND
  } ser_state_e;

endpackage

// File: rtl/qracc_vec_fifo.sv
// Small vector FIFO, pointers carry an extra wrap bit.
// Caller guarantees writes only when a slot is free (or freed same cycle).
module qracc_vec_fifo #(
  parameter int W = 128,
  parameter int D = 2
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 wr_en_i,
  input  logic [W-1:0]         wr_data_i,
  input  logic                 rd_en_i,
  output logic [W-1:0]         rd_data_o,
  output logic [$clog2(D):0]   count_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int AW = $clog2(D);

  logic [AW:0]  wr_q;
  logic [AW:0]  rd_q;
  logic [W-1:0] mem_q [D];

  assign count_o   = wr_q - rd_q;
  assign full_o    = count_o == (AW+1)'(D);
  assign empty_o   = wr_q == rd_q;
  assign rd_data_o = mem_q[rd_q[AW-1:0]];

  // Advance head/tail pointers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (wr_en_i) wr_q <= wr_q + 1'b1;
      if (rd_en_i && !empty_o) rd_q <= rd_q + 1'b1;
    end
  end

  // Storage array, data needs no reset.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/qracc_out_serializer.sv
// Buffers MAC output vectors and serializes them onto a word bus.
// Optional QRACC_OUT_RELU_EN clamps negative elements to zero on write.
module qracc_out_serializer
  import qracc_pkg::*;
#(
  parameter int outputElements = QRACC_OUT_ELEMS,
  parameter int outputBits     = QRACC_OUT_BITS,
  parameter int busWidth       = QRACC_OUT_BUS_W,
  parameter int fifoDepth      = QRACC_OUT_FIFO_D
) (
  input  logic                               clk,
  input  logic                               nrst,
  input  logic                               issue_i,
  input  logic                               vec_valid_i,
  input  logic [outputElements*outputBits-1:0] vec_data_i,
  output logic                               credit_avail_o,
  output logic                               word_valid_o,
  input  logic                               word_ready_i,
  output logic [busWidth-1:0]                word_data_o,
  output logic                               word_last_o,
  output logic                               overflow_o,
  input  logic                               clear_i
);

  localparam int VW  = outputElements * outputBits;
  localparam int EPW = busWidth / outputBits;
  localparam int WPV = (outputElements + EPW - 1) / EPW;
  localparam int IW  = (WPV > 1) ? $clog2(WPV) : 1;
  localparam int CW  = $clog2(fifoDepth) + 1;

  localparam logic [IW-1:0] LAST_IDX = IW'(WPV - 1);
  localparam logic [CW-1:0] CMAX     = CW'(fifoDepth);

  ser_state_e    state_q;
  logic [IW-1:0] idx_q;
  logic [CW-1:0] credit_q;
  logic [CW-1:0] credit_d;
  logic          ovf_q;
  logic          ovf_d;

  logic [VW-1:0] wdata;
  logic [VW-1:0] head;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;

  logic [WPV*busWidth-1:0] pad;

  logic hs;
  logic is_last;
  logic pop;
  logic wr_ok;

  assign word_valid_o = state_q == S_SEND;
  assign is_last      = idx_q == LAST_IDX;
  assign word_last_o  = word_valid_o && is_last;
  assign hs           = word_valid_o && word_ready_i;
  assign pop          = hs && is_last;
  assign wr_ok        = vec_valid_i && (!full || pop);

  assign credit_avail_o = credit_q != '0;
  assign overflow_o     = ovf_q;

  // Optional clamp of negative elements before storage.
  always_comb begin
    wdata = vec_data_i;
`ifdef QRACC_OUT_RELU_EN
    for (int i = 0; i < outputElements; i++) begin
      if (vec_data_i[i*outputBits + outputBits - 1])
        wdata[i*outputBits +: outputBits] = '0;
    end
`endif
  end

  qracc_vec_fifo #(
    .W (VW),
    .D (fifoDepth)
  ) u_fifo (
    .clk       (clk),
    .nrst      (nrst),
    .wr_en_i   (wr_ok),
    .wr_data_i (wdata),
    .rd_en_i   (pop),
    .rd_data_o (head),
    .count_o   (count),
    .full_o    (full),
    .empty_o   (empty)
  );

  // Zero-pad the head so the tail word has empty slots cleared.
  always_comb begin
    pad = '0;
    pad[VW-1:0] = head;
    word_data_o = '0;
    if (word_valid_o)
      word_data_o = pad[idx_q*busWidth +: busWidth];
  end

  // Serializer FSM: word index walks the head vector.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          idx_q <= '0;
          if (!empty) state_q <= S_SEND;
        end
        S_SEND: begin
          if (hs) begin
            if (!is_last) begin
              idx_q <= idx_q + 1'b1;
            end else begin
              idx_q <= '0;
              if (!(count > CW'(1) || wr_ok))
                state_q <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Credit next state: saturates at zero and at the FIFO depth.
  always_comb begin
    credit_d = credit_q;
    if (issue_i && !pop) begin
      if (credit_q != '0) credit_d = credit_q - 1'b1;
    end else if (pop && !issue_i) begin
      if (credit_q < CMAX) credit_d = credit_q + 1'b1;
    end
  end

  // Sticky overflow: a new drop beats a simultaneous clear.
  always_comb begin
    ovf_d = ovf_q;
    if (vec_valid_i && !wr_ok) ovf_d = 1'b1;
    else if (clear_i)          ovf_d = 1'b0;
  end

  // Credit and overflow registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      credit_q <= CMAX;
      ovf_q    <= 1'b0;
    end else begin
      credit_q <= credit_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule
